// File: rtl/smc_pkg.sv
// Shared constants, FSM state type and slot packing helper for the SMC frame collector.
package smc_pkg;

    localparam int NUM_DEV = 6;                 // transistors per frame
    localparam int DW      = 3;                 // width of W / V_GS / V_DS fields
    localparam int OW      = 8;                 // width of the SMC result
    localparam int CW      = $clog2(NUM_DEV);   // beat counter width
    localparam int BW      = NUM_DEV * DW;      // width of one parallel slot bus

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        EVAL    = 2'd2,
        OUT     = 2'd3
    } state_t;

    // Return bus with slot idx (bits [DW*idx+DW-1 : DW*idx]) replaced by val.
    function automatic logic [BW-1:0] put_slot(input logic [BW-1:0] bus,
                                               input logic [CW-1:0] idx,
                                               input logic [DW-1:0] val);
        logic [BW-1:0] r;
        r = bus;
        r[DW*int'(idx) +: DW] = val;
        return r;
    endfunction

endpackage

// File: rtl/smc_frame_collector.sv
// Collects NUM_DEV transistor beats into stable parallel buses for the
// combinational SMC, captures its result one cycle after the last beat and
// returns it with a single-cycle out_valid strobe.
//
// Handshake: a beat is transferred on every rising edge where in_valid=1 and
// the block is in IDLE, COLLECT or OUT; there is no ready, so the source must
// deliver all NUM_DEV beats on consecutive cycles. A gap inside a frame aborts
// it (frame_err), and in_valid during EVAL is dropped (frame_err).
module smc_frame_collector
    import smc_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic [1:0]    mode_in,
    input  logic [DW-1:0] w_in,
    input  logic [DW-1:0] vgs_in,
    input  logic [DW-1:0] vds_in,
    input  logic [OW-1:0] smc_out_n,
    output logic [1:0]    mode_o,
    output logic [BW-1:0] w_bus,
    output logic [BW-1:0] vgs_bus,
    output logic [BW-1:0] vds_bus,
    output logic          busy,
    output logic          out_valid,
    output logic [OW-1:0] out_n,
    output logic          frame_err,
    output state_t        state
);

    logic [CW-1:0] beat_cnt;
    // An EVAL intrusion cannot be flagged in the OUT cycle because frame_err
    // and out_valid must never coincide; it is held here and flagged one
    // cycle after OUT instead.
    logic          err_pend;

    // Frame FSM with beat counter, slot register file and result register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            beat_cnt  <= '0;
            err_pend  <= 1'b0;
            mode_o    <= 2'b00;
            w_bus     <= '0;
            vgs_bus   <= '0;
            vds_bus   <= '0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            out_n     <= '0;
            frame_err <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            frame_err <= 1'b0;
            out_n     <= '0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        w_bus    <= put_slot(w_bus, '0, w_in);
                        vgs_bus  <= put_slot(vgs_bus, '0, vgs_in);
                        vds_bus  <= put_slot(vds_bus, '0, vds_in);
                        mode_o   <= mode_in;
                        beat_cnt <= CW'(1);
                        busy     <= 1'b1;
                        state    <= COLLECT;
                    end
                end
                COLLECT: begin
                    if (in_valid) begin
                        w_bus   <= put_slot(w_bus, beat_cnt, w_in);
                        vgs_bus <= put_slot(vgs_bus, beat_cnt, vgs_in);
                        vds_bus <= put_slot(vds_bus, beat_cnt, vds_in);
                        if (beat_cnt == CW'(NUM_DEV - 1)) begin
                            beat_cnt <= '0;
                            state    <= EVAL;
                        end else begin
                            beat_cnt <= beat_cnt + CW'(1);
                        end
                    end else begin
                        // Gap inside the frame: partial slots stay on the buses.
                        frame_err <= 1'b1;
                        beat_cnt  <= '0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                EVAL: begin
                    out_n     <= smc_out_n;
                    out_valid <= 1'b1;
                    busy      <= 1'b0;
                    err_pend  <= in_valid;
                    state     <= OUT;
                end
                OUT: begin
                    frame_err <= err_pend;
                    err_pend  <= 1'b0;
                    if (in_valid) begin
                        w_bus    <= put_slot(w_bus, '0, w_in);
                        vgs_bus  <= put_slot(vgs_bus, '0, vgs_in);
                        vds_bus  <= put_slot(vds_bus, '0, vds_in);
                        mode_o   <= mode_in;
                        beat_cnt <= CW'(1);
                        busy     <= 1'b1;
                        state    <= COLLECT;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_smc_frame_collector.sv
// Self-checking bench for smc_frame_collector: directed scenarios plus a
// randomized frame stream checked against a slot/timing reference model.
module tb_smc_frame_collector;
    import smc_pkg::*;

    // ---------------- clock / reset ----------------
    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic [1:0]    mode_in = 2'b00;
    logic [DW-1:0] w_in = '0, vgs_in = '0, vds_in = '0;
    logic [OW-1:0] smc_out_n = '0;
    logic [1:0]    mode_o;
    logic [BW-1:0] w_bus, vgs_bus, vds_bus;
    logic          busy, out_valid, frame_err;
    logic [OW-1:0] out_n;
    state_t        state;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    smc_frame_collector dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .mode_in   (mode_in),
        .w_in      (w_in),
        .vgs_in    (vgs_in),
        .vds_in    (vds_in),
        .smc_out_n (smc_out_n),
        .mode_o    (mode_o),
        .w_bus     (w_bus),
        .vgs_bus   (vgs_bus),
        .vds_bus   (vds_bus),
        .busy      (busy),
        .out_valid (out_valid),
        .out_n     (out_n),
        .frame_err (frame_err),
        .state     (state)
    );

    int checks = 0;
    int errors = 0;

    // ---------------- reference model state ----------------
    // Frame to send, and the slot contents the buses must show: slot k holds
    // the value of the most recent accepted beat k (reset clears all slots).
    logic [DW-1:0] fw [NUM_DEV];
    logic [DW-1:0] fg [NUM_DEV];
    logic [DW-1:0] fd [NUM_DEV];
    logic [DW-1:0] mw [NUM_DEV];
    logic [DW-1:0] mg [NUM_DEV];
    logic [DW-1:0] md [NUM_DEV];
    logic [1:0]    mmode;

    // Scoreboard: expected result strobes (cycle + value) and error strobes.
    int            exp_cyc_q[$];
    logic [OW-1:0] exp_q[$];
    int            exp_err_q[$];

    // Observation log filled by the monitor.
    int            ov_cyc_q[$];
    logic [OW-1:0] ov_val_q[$];
    int            err_cyc_q[$];
    int            inv_bad = 0;

    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            ov_cyc_q.push_back(cyc);
            ov_val_q.push_back(out_n);
        end
        if (frame_err === 1'b1) err_cyc_q.push_back(cyc);
        if ((out_valid !== 1'b1 && out_n !== '0) || (out_valid === 1'b1 && frame_err === 1'b1))
            inv_bad++;
    end

    function automatic logic [BW-1:0] slots_value(input logic [DW-1:0] a [NUM_DEV]);
        logic [BW-1:0] r;
        r = '0;
        for (int k = 0; k < NUM_DEV; k++)
            r = r + (BW'(a[k]) << (DW * k));
        return r;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        ov_cyc_q.delete(); ov_val_q.delete(); err_cyc_q.delete();
        exp_cyc_q.delete(); exp_q.delete(); exp_err_q.delete();
    endtask

    task automatic model_reset();
        for (int k = 0; k < NUM_DEV; k++) begin
            mw[k] = '0; mg[k] = '0; md[k] = '0;
        end
        mmode = 2'b00;
    endtask

    task automatic rand_frame();
        for (int k = 0; k < NUM_DEV; k++) begin
            fw[k] = DW'($urandom_range(0, 7));
            fg[k] = DW'($urandom_range(0, 7));
            fd[k] = DW'($urandom_range(0, 7));
        end
    endtask

    // Drive nbeats consecutive beats; returns the cycle of the last beat.
    // Leaves in_valid=0 for the following cycle.
    task automatic drive_frame(input int nbeats, input logic [1:0] mode0,
                               input logic [1:0] mode_rest, input bit rand_rest,
                               input logic [OW-1:0] res, output int last_cyc);
        for (int k = 0; k < nbeats; k++) begin
            in_valid = 1'b1;
            w_in     = fw[k];
            vgs_in   = fg[k];
            vds_in   = fd[k];
            mode_in  = (k == 0) ? mode0 : (rand_rest ? 2'($urandom_range(0, 3)) : mode_rest);
            if (k == nbeats - 1) smc_out_n = res;
            mw[k] = fw[k]; mg[k] = fg[k]; md[k] = fd[k];
            if (k == 0) mmode = mode0;
            last_cyc = cyc;
            step();
        end
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        int lc;
        rst_n = 1'b0;
        model_reset();
        idle(2);
        checks++;
        if ({mode_o, w_bus, vgs_bus, vds_bus, busy, out_valid, out_n, frame_err} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got mode=%0d w=%o g=%o d=%o busy=%b ov=%b n=%0d err=%b, want all 0",
                     mode_o, w_bus, vgs_bus, vds_bus, busy, out_valid, out_n, frame_err);
        end
        checks++;
        if (state !== IDLE) begin errors++; $display("FAIL reset_state: got %0d want IDLE", state); end
        rst_n = 1'b1;
        idle(2);
        clear_logs();
        rand_frame();
        drive_frame(3, 2'b10, 2'b00, 1'b1, 8'd99, lc);
        checks++;
        if (busy !== 1'b1 || state !== COLLECT) begin
            errors++; $display("FAIL reset_precond: busy=%b state=%0d want busy=1 COLLECT", busy, state);
        end
        // Beat 3 on the inputs, then reset lands asynchronously mid-cycle.
        in_valid = 1'b1; w_in = fw[3]; vgs_in = fg[3]; vds_in = fd[3];
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({mode_o, w_bus, vgs_bus, vds_bus, busy, out_valid, out_n, frame_err} !== '0 || state !== IDLE) begin
            errors++;
            $display("FAIL reset_async: got mode=%0d w=%o busy=%b ov=%b n=%0d err=%b state=%0d, want 0/IDLE",
                     mode_o, w_bus, busy, out_valid, out_n, frame_err, state);
        end
        in_valid = 1'b0;
        step(); step();
        rst_n = 1'b1;
        idle(10);
        checks++;
        if (ov_cyc_q.size() != 0 || err_cyc_q.size() != 0) begin
            errors++; $display("FAIL reset_no_output: got %0d out_valid and %0d frame_err strobes, want 0",
                               ov_cyc_q.size(), err_cyc_q.size());
        end
    endtask

    task automatic run_fixed_frame(input logic [1:0] mode_rest, input string tag);
        int t;
        for (int k = 0; k < NUM_DEV; k++) begin
            fw[k] = DW'(k); fg[k] = 3'd7; fd[k] = DW'(k);
        end
        clear_logs();
        in_valid = 1'b1; w_in = fw[0]; vgs_in = fg[0]; vds_in = fd[0]; mode_in = 2'b01;
        t = cyc; mmode = 2'b01; mw[0] = fw[0]; mg[0] = fg[0]; md[0] = fd[0];
        step();
        // Beats 1..5 with the chosen (ignored) mode_in; mode_o must hold 1.
        for (int k = 1; k < NUM_DEV; k++) begin
            checks++;
            if (mode_o !== 2'b01) begin
                errors++; $display("FAIL %s_mode_hold: beat %0d mode_o=%0d want 1", tag, k, mode_o);
            end
            w_in = fw[k]; vgs_in = fg[k]; vds_in = fd[k]; mode_in = mode_rest;
            if (k == NUM_DEV - 1) smc_out_n = 8'd42;
            mw[k] = fw[k]; mg[k] = fg[k]; md[k] = fd[k];
            t = cyc;
            step();
        end
        in_valid = 1'b0;
        // Cycle t+1: EVAL
        checks++;
        if (w_bus !== 18'o543210 || vgs_bus !== 18'o777777 || vds_bus !== 18'o543210 || mode_o !== 2'b01) begin
            errors++; $display("FAIL %s_buses: w=%o g=%o d=%o mode=%0d want 543210/777777/543210/1",
                               tag, w_bus, vgs_bus, vds_bus, mode_o);
        end
        checks++;
        if (busy !== 1'b1 || out_valid !== 1'b0) begin
            errors++; $display("FAIL %s_eval: busy=%b ov=%b want 1/0", tag, busy, out_valid);
        end
        step();
        // Cycle t+2: OUT
        checks++;
        if (out_valid !== 1'b1 || out_n !== 8'd42 || busy !== 1'b0) begin
            errors++; $display("FAIL %s_result: ov=%b n=%0d busy=%b want 1/42/0", tag, out_valid, out_n, busy);
        end
        step();
        checks++;
        if (out_valid !== 1'b0 || out_n !== 8'd0 || state !== IDLE) begin
            errors++; $display("FAIL %s_after: ov=%b n=%0d state=%0d want 0/0/IDLE", tag, out_valid, out_n, state);
        end
        idle(3);
        checks++;
        if (ov_cyc_q.size() != 1 || (ov_cyc_q.size() == 1 && ov_cyc_q[0] != t + 2)) begin
            errors++; $display("FAIL %s_latency: got %0d strobes first at %0d, want 1 at %0d",
                               tag, ov_cyc_q.size(), (ov_cyc_q.size() > 0) ? ov_cyc_q[0] : -1, t + 2);
        end
    endtask

    task automatic test_normal_frame();
        run_fixed_frame(2'b01, "normal");
    endtask

    task automatic test_mode_sampling();
        run_fixed_frame(2'b11, "mode");
    endtask

    task automatic test_abort();
        int lc, lc2;
        logic [OW-1:0] res;
        rand_frame();
        drive_frame(NUM_DEV, 2'b10, 2'b00, 1'b1, 8'd7, lc);
        idle(3);
        clear_logs();
        rand_frame();
        drive_frame(3, 2'b11, 2'b00, 1'b1, 8'd0, lc);
        step();
        checks++;
        if (frame_err !== 1'b1 || out_valid !== 1'b0 || state !== IDLE || busy !== 1'b0) begin
            errors++; $display("FAIL abort_err: err=%b ov=%b state=%0d busy=%b want 1/0/IDLE/0",
                               frame_err, out_valid, state, busy);
        end
        checks++;
        if (w_bus !== slots_value(mw) || vgs_bus !== slots_value(mg) || vds_bus !== slots_value(md)) begin
            errors++; $display("FAIL abort_partial: w=%o g=%o d=%o want %o %o %o",
                               w_bus, vgs_bus, vds_bus, slots_value(mw), slots_value(mg), slots_value(md));
        end
        step();
        checks++;
        if (frame_err !== 1'b0) begin errors++; $display("FAIL abort_pulse: err=%b want 0", frame_err); end
        rand_frame();
        res = OW'($urandom_range(0, 255));
        drive_frame(NUM_DEV, 2'b00, 2'b00, 1'b1, res, lc2);
        idle(4);
        checks++;
        if (ov_cyc_q.size() != 1 || err_cyc_q.size() != 1) begin
            errors++; $display("FAIL abort_counts: got %0d results %0d errors, want 1 and 1",
                               ov_cyc_q.size(), err_cyc_q.size());
        end else if (ov_cyc_q[0] != lc2 + 2 || ov_val_q[0] !== res || err_cyc_q[0] != lc + 2) begin
            errors++; $display("FAIL abort_recover: result %0d at %0d err at %0d, want %0d at %0d err at %0d",
                               ov_val_q[0], ov_cyc_q[0], err_cyc_q[0], res, lc2 + 2, lc + 2);
        end
    endtask

    task automatic test_back_to_back();
        int lc;
        logic [OW-1:0] res;
        clear_logs();
        for (int f = 0; f < 3; f++) begin
            rand_frame();
            res = OW'($urandom_range(0, 255));
            drive_frame(NUM_DEV, 2'($urandom_range(0, 3)), 2'b00, 1'b1, res, lc);
            exp_cyc_q.push_back(lc + 2);
            exp_q.push_back(res);
            idle(1);   // EVAL cycle; next beat 0 lands in OUT
        end
        idle(4);
        checks++;
        if (ov_cyc_q.size() != 3 || err_cyc_q.size() != 0) begin
            errors++; $display("FAIL b2b_counts: got %0d results %0d errors, want 3 and 0",
                               ov_cyc_q.size(), err_cyc_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (ov_cyc_q[i] != exp_cyc_q[i] || ov_val_q[i] !== exp_q[i]) begin
                    errors++; $display("FAIL b2b_result%0d: got %0d at %0d want %0d at %0d",
                                       i, ov_val_q[i], ov_cyc_q[i], exp_q[i], exp_cyc_q[i]);
                end
            end
            // Six beats, beat 0 overlapping the previous OUT cycle: period 7.
            checks++;
            if (ov_cyc_q[1] - ov_cyc_q[0] != NUM_DEV + 1) begin
                errors++; $display("FAIL b2b_spacing: got %0d cycles want %0d", ov_cyc_q[1] - ov_cyc_q[0], NUM_DEV + 1);
            end
        end
    endtask

    task automatic test_eval_intrusion();
        int lc;
        logic [OW-1:0] res;
        clear_logs();
        rand_frame();
        res = OW'($urandom_range(0, 255));
        drive_frame(NUM_DEV, 2'b10, 2'b00, 1'b1, res, lc);
        in_valid = 1'b1; w_in = ~fw[0]; vgs_in = ~fg[0]; vds_in = ~fd[0]; mode_in = 2'b01;
        step();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_n !== res || frame_err !== 1'b0) begin
            errors++; $display("FAIL intrude_result: ov=%b n=%0d err=%b want 1/%0d/0", out_valid, out_n, frame_err, res);
        end
        checks++;
        if (w_bus !== slots_value(mw) || vgs_bus !== slots_value(mg) || vds_bus !== slots_value(md) || mode_o !== 2'b10) begin
            errors++; $display("FAIL intrude_buses: w=%o g=%o d=%o mode=%0d want %o %o %o 2",
                               w_bus, vgs_bus, vds_bus, mode_o, slots_value(mw), slots_value(mg), slots_value(md));
        end
        step();
        checks++;
        if (frame_err !== 1'b1 || out_valid !== 1'b0 || state !== IDLE) begin
            errors++; $display("FAIL intrude_err: err=%b ov=%b state=%0d want 1/0/IDLE", frame_err, out_valid, state);
        end
        step();
        checks++;
        if (frame_err !== 1'b0 || err_cyc_q.size() != 1) begin
            errors++; $display("FAIL intrude_pulse: err=%b strobes=%0d want 0/1", frame_err, err_cyc_q.size());
        end
    endtask

    task automatic test_random_stream();
        int lc, nb;
        logic [OW-1:0] res;
        clear_logs();
        for (int f = 0; f < 25; f++) begin
            rand_frame();
            res = OW'($urandom_range(0, 255));
            nb = ($urandom_range(0, 4) == 0) ? $urandom_range(1, NUM_DEV - 1) : NUM_DEV;
            drive_frame(nb, 2'($urandom_range(0, 3)), 2'b00, 1'b1, res, lc);
            if (nb == NUM_DEV) begin
                exp_cyc_q.push_back(lc + 2);
                exp_q.push_back(res);
                checks++;
                if (w_bus !== slots_value(mw) || vgs_bus !== slots_value(mg) || vds_bus !== slots_value(md) || mode_o !== mmode) begin
                    errors++; $display("FAIL rand_buses%0d: w=%o g=%o d=%o mode=%0d want %o %o %o %0d",
                                       f, w_bus, vgs_bus, vds_bus, mode_o, slots_value(mw), slots_value(mg), slots_value(md), mmode);
                end
            end else begin
                exp_err_q.push_back(lc + 2);
            end
            idle($urandom_range(1, 3));
        end
        idle(4);
        checks++;
        if (ov_cyc_q.size() != exp_cyc_q.size() || err_cyc_q.size() != exp_err_q.size()) begin
            errors++; $display("FAIL rand_counts: got %0d results %0d errors, want %0d and %0d",
                               ov_cyc_q.size(), err_cyc_q.size(), exp_cyc_q.size(), exp_err_q.size());
        end else begin
            for (int i = 0; i < exp_cyc_q.size(); i++) begin
                checks++;
                if (ov_cyc_q[i] != exp_cyc_q[i] || ov_val_q[i] !== exp_q[i]) begin
                    errors++; $display("FAIL rand_result%0d: got %0d at %0d want %0d at %0d",
                                       i, ov_val_q[i], ov_cyc_q[i], exp_q[i], exp_cyc_q[i]);
                end
            end
            for (int i = 0; i < exp_err_q.size(); i++) begin
                checks++;
                if (err_cyc_q[i] != exp_err_q[i]) begin
                    errors++; $display("FAIL rand_err%0d: got cycle %0d want %0d", i, err_cyc_q[i], exp_err_q[i]);
                end
            end
        end
        checks++;
        if (inv_bad != 0) begin
            errors++; $display("FAIL strobe_rules: got %0d cycles with out_n leak or err+valid overlap, want 0", inv_bad);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_normal_frame();
        test_mode_sampling();
        test_abort();
        test_back_to_back();
        test_eval_intrusion();
        test_random_stream();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
